// File: rtl/mux_n_pipe_if.sv
// ============================================================================
//  Module      : mux_n_pipe_if
//  Description : Handshake bundle for mux_n_pipe (upstream select/data side
//                and downstream head-item side).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_n_pipe_if #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
);
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_err;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err_seen;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid, err_seen
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid, err_seen
    );
endinterface

`default_nettype wire

// File: rtl/mux_n_pipe.sv
// ============================================================================
//  Module      : mux_n_pipe
//  Description : N-input select mux with a registered output behind a
//                2-entry skid buffer (valid/ready on both sides).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_n_pipe #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mux_n_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // One extra bit so N_IN == 2**SEL_W is representable.
    localparam logic [SEL_W:0] c_n_in = (SEL_W + 1)'(N_IN);

    state_t           r_state;
    logic [WIDTH-1:0] r_main_data;
    logic             r_main_err;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_err;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_err_seen;

    logic [WIDTH-1:0] w_in [N_IN];
    logic [WIDTH-1:0] w_item_data;
    logic             w_item_err;
    logic             w_acc;
    logic             w_take;

    generate
        for (genvar k = 0; k < N_IN; k++) begin : g_unpack
            assign w_in[k] = bus.in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        w_item_err  = ({1'b0, bus.in_sel} >= c_n_in);
        w_item_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                w_item_data = w_in[k];
            end
        end
    end

    assign w_acc  = bus.in_valid & r_in_ready;
    assign w_take = r_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err_seen  <= 1'b0;
        end else begin
            if (w_acc && w_item_err) begin
                r_err_seen <= 1'b1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main_data <= w_item_data;
                        r_main_err  <= w_item_err;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_take) begin
                        r_main_data <= w_item_data;
                        r_main_err  <= w_item_err;
                    end else if (w_acc) begin
                        // Head is stalled: park the new item in the skid slot.
                        r_skid_data <= w_item_data;
                        r_skid_err  <= w_item_err;
                        r_state     <= ST_FULL;
                        r_in_ready  <= 1'b0;
                    end else if (w_take) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_take) begin
                        r_main_data <= r_skid_data;
                        r_main_err  <= r_skid_err;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main_data;
    assign bus.out_err   = r_main_err;
    assign bus.err_seen  = r_err_seen;

endmodule

`default_nettype wire
